// File: rtl/dma_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared widths, limits and FSM encoding for dma_copy_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

   localparam int DMA_ADDR_W = 10;    // 1024-entry memory
   localparam int DMA_DATA_W = 8;     // byte-wide memory
   localparam int DMA_LEN_W  = 11;    // lengths 0..1024 need 11 bits
   localparam int MAX_LEN    = 1024;  // one full memory image

   // Copy-engine states; explicit 3-bit encoding
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      FIN  = 3'd4
   } state_t;

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_copy_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dma_copy_engine
//  Description : Single-channel memory-to-memory byte copier. Drives the
//                single-port program memory with RD / CAP / WR cycles per
//                byte. Every output is a flop, so start and mem_rdata never
//                reach a pin combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_copy_engine
   import dma_pkg::*;
#(
   parameter int ADDR_W = DMA_ADDR_W,
   parameter int DATA_W = DMA_DATA_W,
   parameter int LEN_W  = DMA_LEN_W
)(
   input  logic              clk,
   input  logic              rst_out,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  xfer_count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_nW_R,
   output logic              mem_ce,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q,   src_d;
   logic [ADDR_W-1:0] dst_q,   dst_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [LEN_W-1:0]  len_q,   len_d;
   logic [LEN_W-1:0]  cnt_q,   cnt_d;      // byte index i, also xfer_count
   logic [DATA_W-1:0] hold_q,  hold_d;     // byte in flight, drives mem_wdata
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic              ce_q,    ce_d;
   logic              nwr_q,   nwr_d;
   logic [LEN_W-1:0]  cnt_inc;

   assign cnt_inc = cnt_q + LEN_W'(1);

   // Next-state, datapath and registered-output precomputation
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      addr_d  = addr_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d = '0;
               if (length == '0) begin
                  // Nothing to move: report completion without touching memory
                  state_d = FIN;
               end else begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  len_d   = (length > C_MAX_LEN) ? C_MAX_LEN : length;
                  state_d = RD;
               end
            end
         end
         RD:  state_d = CAP;
         CAP: begin
            // Memory output register is valid during this cycle
            hold_d  = mem_rdata;
            state_d = WR;
         end
         WR: begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == len_q) ? FIN : RD;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Pins are registered from the state being entered so they line up
      // with that state's cycle.
      busy_d = (state_d == RD) || (state_d == CAP) || (state_d == WR);
      done_d = (state_d == FIN);
      ce_d   = (state_d == RD) || (state_d == WR);
      nwr_d  = (state_d == WR);

      // Address wraps naturally modulo 2^ADDR_W
      if (state_d == RD) begin
         addr_d = src_d + cnt_d[ADDR_W-1:0];
      end else if (state_d == WR) begin
         addr_d = dst_q + cnt_q[ADDR_W-1:0];
      end
   end

   // State and datapath registers; reset takes the memory port off at once
   always_ff @(posedge clk or posedge rst_out) begin
      if (rst_out) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ce_q    <= 1'b0;
         nwr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ce_q    <= ce_d;
         nwr_q   <= nwr_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign xfer_count = cnt_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = hold_q;
   assign mem_nW_R   = nwr_q;
   assign mem_ce     = ce_q;

endmodule : dma_copy_engine
`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dma_copy_engine
//  Description : Scoreboard bench for dma_copy_engine with a 1024x8 memory
//                model that has a registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_copy_engine;

   logic        clk = 1'b0;
   logic        rst_out;
   logic        start;
   logic [9:0]  src_addr, dst_addr;
   logic [10:0] length;
   logic        busy, done, mem_nW_R, mem_ce;
   logic [10:0] xfer_count;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dma_copy_engine dut (
      .clk        (clk),
      .rst_out    (rst_out),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .xfer_count (xfer_count),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_nW_R   (mem_nW_R),
      .mem_ce     (mem_ce),
      .mem_rdata  (mem_rdata)
   );

   // Memory model with a bench-side preload port
   logic [7:0] mem [0:1023];
   logic       pl_en = 1'b0;
   logic [9:0] pl_addr;
   logic [7:0] pl_data;

   always @(posedge clk) begin
      if (pl_en)
         mem[pl_addr] <= pl_data;
      else if (mem_ce) begin
         if (mem_nW_R) mem[mem_addr] <= mem_wdata;
         else          mem_rdata     <= mem[mem_addr];
      end
   end

   int checks = 0;
   int errors = 0;

   logic [17:0] exp_wr[$];     // {addr, data}
   logic [10:0] exp_done[$];   // xfer_count at done
   logic [9:0]  rd_log[$];

   logic [7:0] pat [11] = '{8'h3A, 8'h7F, 8'hC2, 8'h1D, 8'hA9, 8'h4E,
                            8'h95, 8'h6B, 8'hD4, 8'h08, 8'h12};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every write cycle and done pulse against the scoreboard
   always @(negedge clk) begin
      if (!rst_out && mem_ce && mem_nW_R) begin
         if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
         end else
            chk("write", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
      end
      if (!rst_out && done) begin
         if (exp_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got count %0d expected no done", xfer_count);
         end else
            chk("done_count", 32'(xfer_count), 32'(exp_done.pop_front()));
      end
   end

   // Read-address log
   always @(negedge clk) begin
      if (!rst_out && mem_ce && !mem_nW_R) rd_log.push_back(mem_addr);
   end

   task automatic preload(input logic [9:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Called just after a rising edge; the next edge samples start
   task automatic issue(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l);
      start = 1'b1; src_addr = s; dst_addr = d; length = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Waits for done; n0/b0 are cycles/busy cycles already elapsed since the start edge
   task automatic wait_done(input string name, input int len, input int n0, input int b0);
      int  n  = n0;
      int  nb = b0;
      bit  seen = 1'b0;
      for (int k = 0; k < 4000 && !seen; k++) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no done expected done within 4000 cycles", name);
      end else begin
         chk({name, "_latency"}, 32'(n), 32'(3*len + 1));
         chk({name, "_busy_cycles"}, 32'(nb), 32'(3*len));
         @(negedge clk);
         chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_done, saw_ce;
      rst_out = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
      repeat (2) @(posedge clk); #1;

      // Reset state
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ce", 32'(mem_ce), 0);
      chk("rst_nwr", 32'(mem_nW_R), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", 32'(mem_wdata), 0);
      chk("rst_count", 32'(xfer_count), 0);

      for (int i = 0; i < 11; i++) preload(10'(i), pat[i]);
      rst_out = 1'b0;
      @(posedge clk); #1;

      // Basic copy 0..10 -> 100..110
      for (int i = 0; i < 11; i++) exp_wr.push_back({10'(100 + i), pat[i]});
      exp_done.push_back(11'd11);
      issue(10'd0, 10'd100, 11'd11);
      wait_done("basic", 11, 0, 0);
      for (int i = 0; i < 11; i++) chk("basic_mem", 32'(mem[100 + i]), 32'(pat[i]));

      // Pin-level protocol trace, one byte 2 -> 5
      exp_wr.push_back({10'd5, 8'hC2});
      exp_done.push_back(11'd1);
      issue(10'd2, 10'd5, 11'd1);
      @(negedge clk);
      chk("trace_rd_ce", 32'(mem_ce), 1);
      chk("trace_rd_nwr", 32'(mem_nW_R), 0);
      chk("trace_rd_addr", 32'(mem_addr), 2);
      chk("trace_rd_busy", 32'(busy), 1);
      @(negedge clk);
      chk("trace_cap_ce", 32'(mem_ce), 0);
      @(negedge clk);
      chk("trace_wr_ce", 32'(mem_ce), 1);
      chk("trace_wr_nwr", 32'(mem_nW_R), 1);
      chk("trace_wr_addr", 32'(mem_addr), 5);
      chk("trace_wr_data", 32'(mem_wdata), 32'h0C2);
      @(negedge clk);
      chk("trace_fin_done", 32'(done), 1);
      chk("trace_fin_ce", 32'(mem_ce), 0);
      chk("trace_fin_busy", 32'(busy), 0);
      @(posedge clk); #1;
      chk("trace_mem5", 32'(mem[5]), 32'h0C2);

      // Zero length
      rd_log.delete();
      exp_done.push_back(11'd0);
      issue(10'd7, 10'd9, 11'd0);
      @(negedge clk);
      chk("zero_done", 32'(done), 1);
      chk("zero_ce", 32'(mem_ce), 0);
      chk("zero_busy", 32'(busy), 0);
      @(negedge clk);
      chk("zero_done_drop", 32'(done), 0);
      chk("zero_ce_after", 32'(mem_ce), 0);
      chk("zero_no_reads", 32'(rd_log.size()), 0);
      @(posedge clk); #1;

      // Overlapping forward copy 0 -> 1
      for (int i = 1; i <= 4; i++) exp_wr.push_back({10'(i), 8'h3A});
      exp_done.push_back(11'd4);
      issue(10'd0, 10'd1, 11'd4);
      wait_done("overlap", 4, 0, 0);
      for (int i = 1; i <= 4; i++) chk("overlap_mem", 32'(mem[i]), 32'h03A);

      // Address wrap 1022 -> 0
      preload(10'd1022, 8'hAA);
      preload(10'd1023, 8'hBB);
      preload(10'd0, 8'h3A);
      preload(10'd1, 8'h7F);
      rd_log.delete();
      exp_wr.push_back({10'd0, 8'hAA});
      exp_wr.push_back({10'd1, 8'hBB});
      exp_wr.push_back({10'd2, 8'hAA});
      exp_wr.push_back({10'd3, 8'hBB});
      exp_done.push_back(11'd4);
      issue(10'd1022, 10'd0, 11'd4);
      wait_done("wrap", 4, 0, 0);
      chk("wrap_nreads", 32'(rd_log.size()), 4);
      if (rd_log.size() == 4) begin
         chk("wrap_rd0", 32'(rd_log[0]), 1022);
         chk("wrap_rd1", 32'(rd_log[1]), 1023);
         chk("wrap_rd2", 32'(rd_log[2]), 0);
         chk("wrap_rd3", 32'(rd_log[3]), 1);
      end
      chk("wrap_mem0", 32'(mem[0]), 32'h0AA);
      chk("wrap_mem1", 32'(mem[1]), 32'h0BB);
      chk("wrap_mem2", 32'(mem[2]), 32'h0AA);
      chk("wrap_mem3", 32'(mem[3]), 32'h0BB);

      // Second start while busy is ignored
      for (int i = 0; i < 11; i++) preload(10'(i), pat[i]);
      for (int i = 0; i < 11; i++) exp_wr.push_back({10'(200 + i), pat[i]});
      exp_done.push_back(11'd11);
      issue(10'd0, 10'd200, 11'd11);
      repeat (10) @(posedge clk); #1;
      issue(10'd500, 10'd600, 11'd2);
      wait_done("busy_start", 11, 11, 11);
      for (int i = 0; i < 11; i++) chk("busy_start_mem", 32'(mem[200 + i]), 32'(pat[i]));

      // Reset during the second WR cycle aborts the transfer
      preload(10'd301, 8'h5A);
      exp_wr.push_back({10'd300, 8'h3A});
      issue(10'd0, 10'd300, 11'd11);
      repeat (5) @(posedge clk); #1;
      chk("abort_in_wr_ce", 32'(mem_ce), 1);
      chk("abort_in_wr_nwr", 32'(mem_nW_R), 1);
      #1 rst_out = 1'b1;
      #1;
      chk("abort_ce_async", 32'(mem_ce), 0);
      chk("abort_busy_async", 32'(busy), 0);
      repeat (2) @(posedge clk); #1;
      rst_out = 1'b0;
      saw_done = 1'b0; saw_ce = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done)   saw_done = 1'b1;
         if (mem_ce) saw_ce   = 1'b1;
      end
      chk("abort_no_done", 32'(saw_done), 0);
      chk("abort_no_ce", 32'(saw_ce), 0);
      chk("abort_mem300", 32'(mem[300]), 32'h03A);
      chk("abort_mem301", 32'(mem[301]), 32'h05A);

      chk("scoreboard_writes_left", 32'(exp_wr.size()), 0);
      chk("scoreboard_dones_left", 32'(exp_done.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dma_copy_engine
`default_nettype wire
